warning_display_scheduler: RTL and testbench

- Shares one dashboard warning display and buzzer between N independent warning sources, e.g. the brake-oil warning and its sibling fuel, temperature and door warnings.
- Latches each source's warning level and rotates active warnings round-robin, one per DWELL-cycle slot.
- Pulses the buzzer whenever a new warning appears.
- Lets the driver acknowledge, and so suppress, the warning currently shown until that source clears and reasserts.

---
 rtl/warning_display_scheduler.sv | 143 ++++++++++++++
 tb/tb_warning_display_scheduler.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/warning_display_scheduler.sv
// Shares one warning display and buzzer among N level-triggered warning sources.
// Latency: warn_in to display is two edges (input register, then IDLE select); buzzer one edge after rise.
// Backpressure: none; ack suppresses the shown source until its warning drops and reasserts.
module warning_display_scheduler #(
    parameter int N      = 4,
    parameter int CODE_W = 2,
    parameter int DWELL  = 8,
    parameter int BEEP   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      warn_in,
    input  logic              ack,
    output logic              disp_valid,
    output logic [CODE_W-1:0] disp_code,
    output logic              buzzer,
    output logic [N-1:0]      pending
);

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int BP_W = $clog2(BEEP + 1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t              state_q, state_d;
    logic [N-1:0]        warn_q, warn_prev_q;
    logic [N-1:0]        acked_q, acked_d;
    logic [N-1:0]        pending_q;
    logic [N-1:0]        active, rise;
    logic [BP_W-1:0]     beep_q, beep_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [CODE_W-1:0]   cur_q, cur_d;
    logic [CODE_W-1:0]   last_q, last_d;
    logic                sel_found;
    logic [CODE_W-1:0]   sel_idx;

    assign rise    = warn_q & ~warn_prev_q;
    assign active  = warn_q & ~acked_q;
    assign pending = pending_q;
    assign buzzer  = (beep_q != '0);

    // Input register plus a second stage so rising edges of each source can be seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            warn_q      <= '0;
            warn_prev_q <= '0;
            pending_q   <= '0;
        end else begin
            warn_q      <= warn_in;
            warn_prev_q <= warn_q;
            pending_q   <= active;
        end
    end

    // Ack latches for the shown source only; a low warning always wins and clears the latch.
    always_comb begin
        acked_d = acked_q;
        for (int i = 0; i < N; i++) begin
            acked_d[i] = (acked_q[i] | ((state_q == SHOW) && ack && (cur_q == CODE_W'(i))))
                         & warn_q[i];
        end
    end

    // Beep counter: any new rise (re)loads the full pulse length, otherwise count down.
    always_comb begin
        beep_d = beep_q;
        if (|rise) begin
            beep_d = BP_W'(BEEP);
        end else if (beep_q != '0) begin
            beep_d = beep_q - 1'b1;
        end
    end

    // Round-robin pick: first active source after the one most recently shown.
    always_comb begin
        int k;
        k         = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < N; j++) begin
            k = (int'(last_q) + 1 + j) % N;
            if (!sel_found && active[k]) begin
                sel_found = 1'b1;
                sel_idx   = CODE_W'(k);
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            acked_q <= '0;
            beep_q  <= '0;
            dwell_q <= '0;
            cur_q   <= '0;
            last_q  <= CODE_W'(N - 1);
        end else begin
            state_q <= state_d;
            acked_q <= acked_d;
            beep_q  <= beep_d;
            dwell_q <= dwell_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
        end
    end

    // Display FSM: select in IDLE, hold for the dwell slot in SHOW, one blank GAP cycle.
    always_comb begin
        state_d    = state_q;
        dwell_d    = dwell_q;
        cur_d      = cur_q;
        last_d     = last_q;
        disp_valid = 1'b0;
        disp_code  = '0;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    cur_d   = sel_idx;
                    last_d  = sel_idx;
                    dwell_d = DW_W'(DWELL - 1);
                    state_d = SHOW;
                end
            end
            SHOW: begin
                disp_valid = 1'b1;
                disp_code  = cur_q;
                if ((dwell_q == '0) || ack || !active[cur_q]) begin
                    state_d = GAP;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_warning_display_scheduler.sv
// Directed bench for warning_display_scheduler: a per-cycle vector table plus
// hand-written sequences for rotation, mid-show deassert, simultaneous events and reset.
module tb_warning_display_scheduler;

    logic       clock;
    logic       reset;
    logic [3:0] warn_in;
    logic       ack;
    logic       disp_valid;
    logic [1:0] disp_code;
    logic       buzzer;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    warning_display_scheduler #(.N(4), .CODE_W(2), .DWELL(8), .BEEP(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .warn_in    (warn_in),
        .ack        (ack),
        .disp_valid (disp_valid),
        .disp_code  (disp_code),
        .buzzer     (buzzer),
        .pending    (pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] w;
        logic       a;
        logic       v;
        logic [1:0] c;
        logic       b;
        logic [3:0] p;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] w, input logic a, input logic v,
                       input logic [1:0] c, input logic b, input logic [3:0] p);
        vec_t e;
        e.w = w; e.a = a; e.v = v; e.c = c; e.b = b; e.p = p;
        vecs.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, then settle before the caller samples.
    task automatic step(input logic [3:0] w, input logic a);
        warn_in = w;
        ack     = a;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] w);
        reset   = 1'b0;
        warn_in = w;
        ack     = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        warn_in = 4'b0000;
        ack     = 1'b0;

        // ---------------- Rotation from reset with all sources high ----------------
        do_reset(4'b1111);
        chk("rst_valid", disp_valid, 1'b0);
        chk("rst_buzzer", buzzer, 1'b0);
        chk("rst_pending", pending, 4'b0000);
        chk("rst_code", disp_code, 2'd0);
        step(4'b1111, 1'b0);
        chk("rot_first_valid", disp_valid, 1'b0);
        chk("rot_first_buzzer", buzzer, 1'b0);
        for (int t = 0; t < 50; t++) begin
            step(4'b1111, 1'b0);
            chk($sformatf("rot_valid_%0d", t), disp_valid, ((t % 10) < 8) ? 1'b1 : 1'b0);
            chk($sformatf("rot_code_%0d", t), disp_code,
                ((t % 10) < 8) ? 32'((t / 10) % 4) : 32'd0);
            chk($sformatf("rot_buzzer_%0d", t), buzzer, (t < 4) ? 1'b1 : 1'b0);
            chk($sformatf("rot_pending_%0d", t), pending, 4'b1111);
        end

        // ---------------- Table: single warning on source 2, reshow, ack, reassert ----------------
        do_reset(4'b0000);
        step(4'b0000, 1'b0);
        add(4'b0100, 0, 0, 0, 0, 4'b0000);
        add(4'b0100, 0, 1, 2, 1, 4'b0100);
        for (int i = 0; i < 3; i++) add(4'b0100, 0, 1, 2, 1, 4'b0100);
        for (int i = 0; i < 4; i++) add(4'b0100, 0, 1, 2, 0, 4'b0100);
        add(4'b0100, 0, 0, 0, 0, 4'b0100);   // GAP
        add(4'b0100, 0, 0, 0, 0, 4'b0100);   // IDLE
        add(4'b0100, 0, 1, 2, 0, 4'b0100);   // reshown
        add(4'b0100, 1, 0, 0, 0, 4'b0100);   // ack -> GAP
        add(4'b0100, 0, 0, 0, 0, 4'b0000);
        add(4'b0100, 0, 0, 0, 0, 4'b0000);   // parked blank
        add(4'b0000, 0, 0, 0, 0, 4'b0000);   // drop
        add(4'b0100, 0, 0, 0, 0, 4'b0000);   // reassert
        add(4'b0100, 0, 1, 2, 1, 4'b0100);   // new beep + reshow
        add(4'b0100, 0, 1, 2, 1, 4'b0100);
        foreach (vecs[i]) begin
            step(vecs[i].w, vecs[i].a);
            chk($sformatf("vec%0d_valid", i), disp_valid, vecs[i].v);
            chk($sformatf("vec%0d_code", i), disp_code, vecs[i].c);
            chk($sformatf("vec%0d_buzzer", i), buzzer, vecs[i].b);
            chk($sformatf("vec%0d_pending", i), pending, vecs[i].p);
        end

        // ---------------- Deassert mid-show ----------------
        do_reset(4'b0000);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        chk("deas_show1_code", disp_code, 2'd1);
        step(4'b1010, 1'b0);
        step(4'b1010, 1'b0);
        step(4'b1000, 1'b0);                 // warn_q[1] falls at this edge
        chk("deas_still_show", disp_valid, 1'b1);
        step(4'b1000, 1'b0);
        chk("deas_gap", disp_valid, 1'b0);
        chk("deas_pending", pending, 4'b1000);
        step(4'b1000, 1'b0);
        chk("deas_idle", disp_valid, 1'b0);
        step(4'b1000, 1'b0);
        chk("deas_next_valid", disp_valid, 1'b1);
        chk("deas_next_code", disp_code, 2'd3);
        step(4'b1010, 1'b0);                 // source 1 returns, never acked
        step(4'b1010, 1'b0);
        chk("deas_src1_pending", pending, 4'b1010);

        // ---------------- Ack on last dwell cycle ----------------
        do_reset(4'b0000);
        step(4'b0001, 1'b0);
        for (int i = 0; i < 8; i++) step(4'b0001, 1'b0);
        chk("lastack_show", disp_valid, 1'b1);
        step(4'b0001, 1'b1);
        chk("lastack_gap", disp_valid, 1'b0);
        step(4'b0001, 1'b0);
        chk("lastack_pending", pending, 4'b0000);
        step(4'b0001, 1'b0);
        chk("lastack_parked", disp_valid, 1'b0);
        step(4'b0001, 1'b0);
        chk("lastack_parked2", disp_valid, 1'b0);

        // ---------------- Ack in the cycle warn_q falls ----------------
        do_reset(4'b0000);
        step(4'b0010, 1'b0);
        step(4'b0010, 1'b0);
        chk("ackfall_show", disp_code, 2'd1);
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);                 // warn_q[1] now low, still in SHOW
        step(4'b0010, 1'b1);                 // ack while warn_q[1]=0
        chk("ackfall_gap", disp_valid, 1'b0);
        step(4'b0010, 1'b0);
        chk("ackfall_pending", pending, 4'b0010);
        step(4'b0010, 1'b0);
        chk("ackfall_reshow_valid", disp_valid, 1'b1);
        chk("ackfall_reshow_code", disp_code, 2'd1);

        // ---------------- Beep retrigger ----------------
        do_reset(4'b0000);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("retrig_beep_on", buzzer, 1'b1);
        step(4'b1001, 1'b0);                 // source 3 rises during beep
        for (int i = 0; i < 4; i++) begin
            step(4'b1001, 1'b0);
            chk($sformatf("retrig_hold_%0d", i), buzzer, 1'b1);
        end
        step(4'b1001, 1'b0);
        chk("retrig_off", buzzer, 1'b0);

        // ---------------- Asynchronous reset mid-show ----------------
        do_reset(4'b0000);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        chk("arst_pre_valid", disp_valid, 1'b1);
        chk("arst_pre_buzzer", buzzer, 1'b1);
        reset = 1'b0;
        #1;
        chk("arst_valid", disp_valid, 1'b0);
        chk("arst_buzzer", buzzer, 1'b0);
        chk("arst_pending", pending, 4'b0000);
        chk("arst_code", disp_code, 2'd0);
        do_reset(4'b1000);
        step(4'b1000, 1'b0);
        chk("arst_rel1_valid", disp_valid, 1'b0);
        step(4'b1000, 1'b0);
        chk("arst_rel2_valid", disp_valid, 1'b1);
        chk("arst_rel2_code", disp_code, 2'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
